// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the slow-clock run/step/burst controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_e;

  localparam int DEF_PERIOD_W = 32;
  localparam int DEF_BURST_W  = 16;
  localparam int MIN_PERIOD   = 1;

endpackage

// File: rtl/tick_gen.sv
// Phase counter and period latch; flags when a tick is due and registers the
// one-cycle tick that the controller accepts via fire.
module tick_gen
  import clk_ctrl_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                fire,
  input  logic [PERIOD_W-1:0] period,
  output logic                due,
  output logic                tick
);

  logic [PERIOD_W-1:0] phase;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] per_eff;

  assign per_eff = (period == '0) ? PERIOD_W'(MIN_PERIOD) : period;
  assign due     = en && (phase == per_q - PERIOD_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      per_q <= PERIOD_W'(MIN_PERIOD);
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        phase <= '0;
        per_q <= per_eff;
      end else if (fire) begin
        // The period is only re-sampled at tick boundaries.
        phase <= '0;
        per_q <= per_eff;
        tick  <= 1'b1;
      end else if (en) begin
        phase <= phase + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/burst tick scheduler for the processor's slow clock.
// Optional breakpoint on tick_count is built only with CLKCTRL_BREAK_EN.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int BURST_W  = DEF_BURST_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic                run,
  input  logic                halt,
  input  logic                step,
  input  logic                burst_go,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [BURST_W-1:0]  break_val,
  output logic                tick,
  output logic                busy,
  output logic [1:0]          state,
  output logic [BURST_W-1:0]  tick_count,
  output logic                brk_hit
);

  state_e             state_q;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] cnt_next;
  logic               due;
  logic               fire;
  logic               start;
  logic               brk_now;

  // A due tick is dropped on halt, or when run has fallen while in RUN.
  assign fire     = due && !halt && (run || state_q != RUN);
  assign start    = !halt && (state_q == IDLE) &&
                    (run || step || (burst_go && burst_len != '0));
  assign cnt_next = tick_count + BURST_W'(1);

  tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (halt || state_q == IDLE),
    .en     (state_q != IDLE),
    .fire   (fire),
    .period (period),
    .due    (due),
    .tick   (tick)
  );

`ifdef CLKCTRL_BREAK_EN
  assign brk_now = fire && (break_val != '0) && (cnt_next == break_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          brk_hit <= 1'b0;
    else if (brk_now) brk_hit <= 1'b1;
    else if (start)   brk_hit <= 1'b0;
  end
`else
  logic unused_break;
  assign unused_break = ^break_val;
  assign brk_now      = 1'b0;
  assign brk_hit      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      remaining  <= '0;
      tick_count <= '0;
    end else begin
      if (fire) tick_count <= cnt_next;
      if (halt) begin
        state_q   <= IDLE;
        remaining <= '0;
      end else begin
        if (fire && state_q == BURST) remaining <= remaining - BURST_W'(1);
        unique case (state_q)
          IDLE: begin
            if (run) begin
              state_q <= RUN;
            end else if (burst_go && burst_len != '0) begin
              state_q   <= BURST;
              remaining <= burst_len;
            end else if (step) begin
              state_q <= STEP;
            end
          end
          RUN: begin
            if (!run || brk_now) state_q <= IDLE;
          end
          STEP, BURST: begin
            if (brk_now)
              state_q <= IDLE;
            else if (run)
              state_q <= RUN;
            else if (fire && (state_q == STEP || remaining == BURST_W'(1)))
              state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign state = state_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed self-checking bench for clk_step_ctrl; honours CLKCTRL_BREAK_EN.
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] period;
  logic        run, halt, step, burst_go;
  logic [15:0] burst_len, break_val;
  logic        tick, busy, brk_hit;
  logic [1:0]  state;
  logic [15:0] tick_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_step_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .period     (period),
    .run        (run),
    .halt       (halt),
    .step       (step),
    .burst_go   (burst_go),
    .burst_len  (burst_len),
    .break_val  (break_val),
    .tick       (tick),
    .busy       (busy),
    .state      (state),
    .tick_count (tick_count),
    .brk_hit    (brk_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; period = 32'd4; run = 1'b0; halt = 1'b0; step = 1'b0;
    burst_go = 1'b0; burst_len = '0; break_val = '0;
    #22;
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_brk", brk_hit, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      check("idle_tick", tick, 0);
      check("idle_state", state, 0);
      check("idle_count", tick_count, 0);
    end

    // Single step, period 4: tick only at E0+4
    step = 1'b1; clk_edge(); step = 1'b0;
    check("step_state", state, 2);
    check("step_busy", busy, 1);
    for (int i = 1; i <= 5; i++) begin
      clk_edge();
      check($sformatf("step_tick_%0d", i), tick, (i == 4) ? 1 : 0);
      if (i == 4) begin
        check("step_count", tick_count, 1);
        check("step_idle", state, 0);
      end
    end

    // Zero-length burst is ignored
    burst_len = 16'd0; burst_go = 1'b1; clk_edge(); burst_go = 1'b0;
    check("burst0_state", state, 0);

    // Burst of 5, period 3, with a stray step at E0+7
    period = 32'd3; burst_len = 16'd5; burst_go = 1'b1; clk_edge(); burst_go = 1'b0;
    check("burst_state", state, 3);
    for (int i = 1; i <= 17; i++) begin
      step = (i == 7);
      clk_edge();
      check($sformatf("burst_tick_%0d", i), tick, (i % 3 == 0 && i <= 15) ? 1 : 0);
      if (i == 7)  check("burst_step_ignored", state, 3);
      if (i == 15) check("burst_end_state", state, 0);
    end
    step = 1'b0;
    check("burst_count", tick_count, 6);

    // Run with period 2, period changed to 5 at the E0+6 tick, run drops at E0+14
    period = 32'd2; run = 1'b1; clk_edge();
    check("run_state", state, 1);
    for (int i = 1; i <= 18; i++) begin
      if (i == 6)  period = 32'd5;
      if (i == 14) run = 1'b0;
      clk_edge();
      check($sformatf("run_tick_%0d", i), tick,
            (i == 2 || i == 4 || i == 6 || i == 11) ? 1 : 0);
      if (i == 14) check("run_stop_state", state, 0);
    end
    check("run_count", tick_count, 10);

    // Burst of 100 at period 1, halted at E0+11
    period = 32'd1; burst_len = 16'd100; burst_go = 1'b1; clk_edge(); burst_go = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      halt = (i == 11);
      clk_edge();
      check($sformatf("halt_tick_%0d", i), tick, (i <= 10) ? 1 : 0);
      if (i == 11) check("halt_state", state, 0);
    end
    halt = 1'b0;
    check("halt_count", tick_count, 20);
    check("halt_busy", busy, 0);

    // halt beats run from IDLE
    run = 1'b1; halt = 1'b1; clk_edge();
    check("halt_over_run", state, 0);
    halt = 1'b0; run = 1'b0;

    // Async reset while tick is high
    period = 32'd3; run = 1'b1; clk_edge();
    repeat (3) clk_edge();
    check("pre_rst_tick", tick, 1);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tick", tick, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_state", state, 0);
    check("async_rst_count", tick_count, 0);
    check("async_rst_brk", brk_hit, 0);
    run = 1'b0;
    #2 rst = 1'b0;

    // Breakpoint at tick 3, period 1, run held
    break_val = 16'd3; period = 32'd1; run = 1'b1; clk_edge();
`ifdef CLKCTRL_BREAK_EN
    for (int i = 1; i <= 3; i++) begin
      clk_edge();
      check($sformatf("brk_tick_%0d", i), tick, 1);
    end
    check("brk_state", state, 0);
    check("brk_hit_set", brk_hit, 1);
    check("brk_count", tick_count, 3);
    run = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      clk_edge();
      check($sformatf("brk_quiet_%0d", i), tick, 0);
      check($sformatf("brk_sticky_%0d", i), brk_hit, 1);
    end
    step = 1'b1; clk_edge(); step = 1'b0;
    check("brk_hit_clear", brk_hit, 0);
`else
    for (int i = 1; i <= 6; i++) begin
      clk_edge();
      check($sformatf("nobrk_tick_%0d", i), tick, 1);
      check($sformatf("nobrk_flag_%0d", i), brk_hit, 0);
      check($sformatf("nobrk_state_%0d", i), state, 1);
    end
    check("nobrk_count", tick_count, 6);
    run = 1'b0;
`endif
    clk_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
